// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, state encoding, ALU codes and instruction field helpers
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_MOVE = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MOVE, S_ALU1, S_ALU2, S_ALU3, S_RETIRE
  } state_t;

  // Instruction layout is {opcode, rx, ry}; helpers take the index width at run time.
  function automatic logic [7:0] instr_op(input logic [31:0] instr, input int idx_w);
    return 8'(instr >> (2 * idx_w));
  endfunction

  function automatic logic [3:0] instr_rx(input logic [31:0] instr, input int idx_w);
    return 4'((instr >> idx_w) & ((32'd1 << idx_w) - 32'd1));
  endfunction

  function automatic logic [3:0] instr_ry(input logic [31:0] instr, input int idx_w);
    return 4'(instr & ((32'd1 << idx_w) - 32'd1));
  endfunction

  // ALU opcodes are contiguous from ADD, so the ALU mode is an offset.
  function automatic logic [2:0] alu_code(input logic [2:0] op);
    return 3'(op - OP_ADD);
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_onehot_dec.sv
// rtl/cpu_ctrl_seq_onehot_dec.sv - gated index to one-hot decoder
module onehot_dec #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] oh
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh[i] = en & (idx == W'(i));
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - multi-cycle control sequencer for the bus-based datapath CPU
module cpu_ctrl_seq #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3,
  parameter int OP_W     = 4,
  parameter int INSTR_W  = OP_W + 2 * IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instruction,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [NUM_REGS-1:0] reg_oe,
  output logic                ext_oe,
  output logic                a_en,
  output logic                g_en,
  output logic                g_oe,
  output logic [2:0]          alu_op,
  output logic                done,
  output logic                illegal
);
  import cpu_ctrl_pkg::*;

  localparam logic [IDX_W:0] LIM = (IDX_W + 1)'(NUM_REGS);

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_rx, r_ry;
  logic             r_illegal;

  logic [7:0]       w_op;
  logic [IDX_W-1:0] w_rx, w_ry, w_oe_idx;
  logic             w_op_bad, w_rx_bad, w_ry_bad, w_illegal;
  logic             w_accept, w_en_en, w_oe_en;

  assign w_op     = instr_op(32'(instruction), IDX_W);
  assign w_rx     = IDX_W'(instr_rx(32'(instruction), IDX_W));
  assign w_ry     = IDX_W'(instr_ry(32'(instruction), IDX_W));
  assign w_op_bad = |w_op[7:3];
  assign w_rx_bad = {1'b0, w_rx} >= LIM;
  assign w_ry_bad = {1'b0, w_ry} >= LIM;

  // Operand range is only checked for the fields the opcode actually uses.
  assign w_illegal = w_op_bad
                   | ((w_op[2:0] != OP_NOP) & w_rx_bad)
                   | ((w_op[2:0] != OP_NOP) & (w_op[2:0] != OP_LOAD) & w_ry_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= w_op[2:0];
        r_rx      <= w_rx;
        r_ry      <= w_ry;
        r_illegal <= w_illegal;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_en_en     = 1'b0;
    w_oe_en     = 1'b0;
    w_oe_idx    = r_rx;
    instr_ready = 1'b0;
    ext_oe      = 1'b0;
    a_en        = 1'b0;
    g_en        = 1'b0;
    g_oe        = 1'b0;
    alu_op      = ALU_ADD;
    done        = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          instr_ready = 1'b1;
          w_accept    = instr_valid;
          if (instr_valid) begin
            if (w_illegal || w_op[2:0] == OP_NOP) w_next = S_RETIRE;
            else if (w_op[2:0] == OP_LOAD)         w_next = S_LOAD;
            else if (w_op[2:0] == OP_MOVE)         w_next = S_MOVE;
            else                                   w_next = S_ALU1;
          end
        end
        S_LOAD: begin
          ext_oe  = 1'b1;
          w_en_en = 1'b1;
          done    = 1'b1;
          w_next  = S_IDLE;
        end
        S_MOVE: begin
          w_oe_en  = 1'b1;
          w_oe_idx = r_ry;
          w_en_en  = 1'b1;
          done     = 1'b1;
          w_next   = S_IDLE;
        end
        S_ALU1: begin
          w_oe_en = 1'b1;
          a_en    = 1'b1;
          w_next  = S_ALU2;
        end
        S_ALU2: begin
          w_oe_en  = 1'b1;
          w_oe_idx = r_ry;
          g_en     = 1'b1;
          alu_op   = alu_code(r_op);
          w_next   = S_ALU3;
        end
        S_ALU3: begin
          g_oe    = 1'b1;
          w_en_en = 1'b1;
          done    = 1'b1;
          w_next  = S_IDLE;
        end
        S_RETIRE: begin
          done    = 1'b1;
          illegal = r_illegal;
          w_next  = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  onehot_dec #(.N(NUM_REGS), .W(IDX_W)) u_reg_en (
    .idx (r_rx),
    .en  (w_en_en),
    .oh  (reg_en)
  );

  onehot_dec #(.N(NUM_REGS), .W(IDX_W)) u_reg_oe (
    .idx (w_oe_idx),
    .en  (w_oe_en),
    .oh  (reg_oe)
  );

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - scoreboard bench for cpu_ctrl_seq
module tb_cpu_ctrl_seq;
  localparam int NR = 8;

  typedef logic [25:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv = 1'b0, rdy, ext, a, g, goe, dn, ill;
  logic [9:0] ins = '0;
  logic [7:0] en, oe;
  logic [2:0] aop;

  logic       iv6 = 1'b0, rdy6, ext6, a6, g6, goe6, dn6, ill6;
  logic [9:0] ins6 = '0;
  logic [5:0] en6, oe6;
  logic [2:0] aop6;

  cpu_ctrl_seq #(.NUM_REGS(8), .IDX_W(3), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(iv), .instr_ready(rdy), .instruction(ins),
    .reg_en(en), .reg_oe(oe), .ext_oe(ext), .a_en(a), .g_en(g), .g_oe(goe),
    .alu_op(aop), .done(dn), .illegal(ill)
  );

  cpu_ctrl_seq #(.NUM_REGS(6), .IDX_W(3), .OP_W(4)) dut6 (
    .clk(clk), .rst(rst), .instr_valid(iv6), .instr_ready(rdy6), .instruction(ins6),
    .reg_en(en6), .reg_oe(oe6), .ext_oe(ext6), .a_en(a6), .g_en(g6), .g_oe(goe6),
    .alu_op(aop6), .done(dn6), .illegal(ill6)
  );

  vec_t got;
  assign got = {rdy, en, oe, ext, a, g, goe, aop, dn, ill};

  vec_t q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, last_acc = 0, prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic vec_t mk(input logic rdy_i, input logic [7:0] en_i, oe_i,
                              input logic ext_i, a_i, g_i, goe_i,
                              input logic [2:0] aop_i, input logic dn_i, ill_i);
    return {rdy_i, en_i, oe_i, ext_i, a_i, g_i, goe_i, aop_i, dn_i, ill_i};
  endfunction

  // Reference model: per-cycle outputs following an accept, ending with the next idle cycle.
  task automatic push_expect(input logic [3:0] op, input logic [2:0] rx, ry);
    logic [7:0] ex, ey;
    logic       bad;
    ex  = 8'd1 << rx;
    ey  = 8'd1 << ry;
    bad = (op > 4'd7) || (op != 4'd7 && int'(rx) >= NR)
          || (op >= 4'd1 && op <= 4'd6 && int'(ry) >= NR);
    if (bad || op == 4'd7)    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, bad));
    else if (op == 4'd0)      q.push_back(mk(0, ex, 0, 1, 0, 0, 0, 0, 1, 0));
    else if (op == 4'd1)      q.push_back(mk(0, ex, ey, 0, 0, 0, 0, 0, 1, 0));
    else begin
      q.push_back(mk(0, 0, ex, 0, 1, 0, 0, 0, 0, 0));
      q.push_back(mk(0, 0, ey, 0, 0, 1, 0, 3'(op - 4'd2), 0, 0));
      q.push_back(mk(0, ex, 0, 0, 0, 0, 1, 0, 1, 0));
    end
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) chk("seq", got, q.pop_front());
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] rx, ry, input bit hold);
    bit ok;
    ok  = 1'b0;
    ins = {op, rx, ry};
    iv  = 1'b1;
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      ok = rdy;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      iv = 1'b0;
      return;
    end
    @(posedge clk);
    push_expect(op, rx, ry);
    #1;
    prev_acc = last_acc;
    last_acc = cyc;
    if (!hold) iv = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 32 && q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic issue6(input logic [3:0] op, input logic [2:0] rx, ry,
                        input logic [5:0] xen, xoe, input logic xext, xill);
    bit ok;
    ok   = 1'b0;
    ins6 = {op, rx, ry};
    iv6  = 1'b1;
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      ok = rdy6;
    end
    if (!ok) begin
      chk("d6_accept_timeout", 0, 1);
      iv6 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    iv6 = 1'b0;
    @(negedge clk);
    chk("d6_done", dn6, 1);
    chk("d6_illegal", ill6, xill);
    chk("d6_reg_en", en6, xen);
    chk("d6_reg_oe", oe6, xoe);
    chk("d6_ext_oe", ext6, xext);
    chk("d6_alu_ctl", {a6, g6, goe6, aop6}, 0);
    @(negedge clk);
    chk("d6_ready", rdy6, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", got, 0);
    chk("reset_out6", {rdy6, en6, oe6, ext6, dn6, ill6}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", got, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    issue(4'd0, 3'd5, 3'd0, 1'b0);
    drain();
    issue(4'd2, 3'd2, 3'd6, 1'b0);
    drain();

    issue(4'd3, 3'd3, 3'd1, 1'b1);
    issue(4'd4, 3'd4, 3'd7, 1'b0);
    chk("b2b_gap", last_acc - prev_acc, 4);
    drain();

    issue(4'hA, 3'd1, 3'd2, 1'b0);
    issue(4'd1, 3'd3, 3'd3, 1'b0);
    issue(4'd5, 3'd0, 3'd7, 1'b0);
    issue(4'd6, 3'd7, 3'd0, 1'b0);
    issue(4'd7, 3'd2, 3'd2, 1'b0);
    issue(4'hF, 3'd0, 3'd0, 1'b0);
    drain();

    for (int k = 0; k < 20; k++)
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    drain();

    // Instruction bus changes after acceptance must not disturb the latched fields.
    issue(4'd5, 3'd1, 3'd0, 1'b0);
    @(posedge clk);
    #1 ins = {4'd0, 3'd6, 3'd6};
    drain();

    // Reset in ALU2 aborts: zero outputs while rst is high, then idle.
    issue(4'd3, 3'd4, 3'd5, 1'b0);
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drain();

    issue6(4'd1, 3'd7, 3'd0, 6'h00, 6'h00, 1'b0, 1'b1);
    issue6(4'd1, 3'd6, 3'd1, 6'h00, 6'h00, 1'b0, 1'b1);
    issue6(4'd1, 3'd0, 3'd6, 6'h00, 6'h00, 1'b0, 1'b1);
    issue6(4'd0, 3'd2, 3'd7, 6'h04, 6'h00, 1'b1, 1'b0);
    issue6(4'd1, 3'd5, 3'd0, 6'h20, 6'h01, 1'b0, 1'b0);
    issue6(4'd7, 3'd7, 3'd7, 6'h00, 6'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Parametrised control sequencer for the bus-based datapath CPU. It accepts one instruction per valid/ready handshake, latches it, and steps a multi-cycle state machine. Each cycle it drives one-hot register enable and tri-state output vectors, plus the accumulator, result and ALU-mode controls. It supersedes the fixed 8-register, 4-op controller with a configurable register file size, seven operations, illegal-instruction detection and an instruction handshake.

Parameters:
NUM_REGS, 8, number of general registers (2..16)
IDX_W, 3, register index width; must satisfy 2**IDX_W >= NUM_REGS
OP_W, 4, opcode width
INSTR_W, OP_W+2*IDX_W, instruction width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept
instruction  in  INSTR_W  {opcode, rx, ry}; rx = destination/first operand, ry = source/second operand
reg_en  out  NUM_REGS  one-hot register load enable
reg_oe  out  NUM_REGS  one-hot register bus drive
ext_oe  out  1  external data onto bus
a_en  out  1  accumulator A load
g_en  out  1  result G load
g_oe  out  1  G drives bus
alu_op  out  3  0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR
done  out  1  one-cycle pulse, instruction retired (program counter increment)
illegal  out  1  one-cycle pulse with done for a rejected instruction

Behaviour:
- Opcodes: 0 LOAD, 1 MOVE, 2 ADD, 3 SUB, 4 XOR, 5 AND, 6 OR, 7 NOP. Opcodes 8..15 are illegal.
- States: IDLE, LOAD, MOVE, ALU1, ALU2, ALU3, RETIRE.
- Reset: the state goes to IDLE at the clk edge when rst=1. While rst=1, every output is 0, including instr_ready.
- IDLE: instr_ready=1 and all controls are 0. On instr_valid & instr_ready the sequencer latches opcode, rx and ry. All outputs decode from the state and the latched fields only, so instruction changes after acceptance have no effect.
- Transitions from IDLE on accept:
  - LOAD or MOVE -> the matching state.
  - ALU ops -> ALU1.
  - NOP -> RETIRE.
  - Illegal opcode, or rx >= NUM_REGS, or ry >= NUM_REGS (checked only for operands the op uses; ry is unused by LOAD) -> RETIRE with the illegal flag set.
- LOAD (1 cycle): ext_oe=1, reg_en[rx]=1, done=1 -> IDLE.
- MOVE (1 cycle): reg_oe[ry]=1, reg_en[rx]=1, done=1 -> IDLE. MOVE with rx==ry is legal and behaves the same.
- ALU1: reg_oe[rx]=1, a_en=1.
- ALU2: reg_oe[ry]=1, g_en=1, alu_op=latched op code.
- ALU3: g_oe=1, reg_en[rx]=1, done=1 -> IDLE.
- RETIRE: done=1, illegal=flag, all enables 0 -> IDLE.
- Latency from the accept edge: LOAD, MOVE, NOP and illegal pulse done in the next cycle; ALU ops pulse done on the third cycle. Throughput is one instruction per 2 cycles (single-cycle ops) or 4 cycles (ALU ops). There is no back-to-back accept.
- Invariants: at most one of {reg_oe bits, ext_oe, g_oe} is high in any cycle (no bus contention). reg_en and reg_oe are each one-hot or zero. alu_op is 0 outside ALU2.
- rst asserted mid-instruction aborts it. No done is issued and no enable is asserted in the reset cycle. The sequencer is in IDLE on the first cycle after rst drops.

Decomposition:
- Package cpu_ctrl_pkg holds the opcode localparams, the state encoding, the alu_op codes and the instruction field-slice helpers.
- One sub-module, onehot_dec (parameters N, W; inputs idx and en; output N-bit one-hot), is instantiated twice: for reg_en (index rx) and reg_oe (index rx or ry, muxed by state).

Test Plan:
- Reset, then LOAD rx=5 with instr_valid held -> accept in IDLE; next cycle ext_oe=1, reg_en=8'h20, done=1; following cycle instr_ready=1.
- ADD rx=2, ry=6 -> ALU1: reg_oe=8'h04, a_en=1; ALU2: reg_oe=8'h40, g_en=1, alu_op=0; ALU3: g_oe=1, reg_en=8'h04, done=1.
- SUB then XOR back-to-back with instr_valid held -> second accept exactly 4 cycles after the first; alu_op is 1 then 2 in the respective ALU2 cycles.
- Opcode 4'hA, then NUM_REGS=6 with MOVE rx=7 -> one cycle with done=1, illegal=1, all enables 0 in both cases.
- Change instruction during ALU2 -> no effect on outputs; the originally latched rx still gets reg_en in ALU3.
- Assert rst during ALU2 -> next cycle all outputs 0, no done pulse; after rst drops, instr_ready=1 on the first cycle.
